axi_stream_header_arbiter: RTL

Round-robin packet arbiter that shares one axi_stream_insert_header instance between NUM_SRC packet sources. Each source presents a header channel and a data channel. The arbiter grants one source per packet, forwards that source's header first and then its data beats, and releases the grant on the last beat. It sits directly upstream of the header-insert block.

---
 rtl/axi_stream_header_arbiter_if.sv | 30 +++
 rtl/axi_stream_header_arbiter.sv | 119 +++++++++++
 2 files changed

// File: rtl/axi_stream_header_arbiter_if.sv
// Header + data stream bundle. LANES parallel channels share one interface;
// the source side of the arbiter uses LANES=NUM_SRC, the sink side LANES=1.
interface axi_stream_header_arbiter_if #(
   parameter int LANES        = 1,
   parameter int DATA_WD      = 32,
   parameter int DATA_BYTE_WD = DATA_WD / 8
);
   logic [LANES-1:0]              valid_insert;
   logic [LANES*DATA_WD-1:0]      data_insert;
   logic [LANES*DATA_BYTE_WD-1:0] keep_insert;
   logic [LANES-1:0]              ready_insert;

   logic [LANES-1:0]              valid_in;
   logic [LANES*DATA_WD-1:0]      data_in;
   logic [LANES*DATA_BYTE_WD-1:0] keep_in;
   logic [LANES-1:0]              last_in;
   logic [LANES-1:0]              ready_in;

   modport master (
      output valid_insert, data_insert, keep_insert,
      output valid_in, data_in, keep_in, last_in,
      input  ready_insert, ready_in
   );

   modport slave (
      input  valid_insert, data_insert, keep_insert,
      input  valid_in, data_in, keep_in, last_in,
      output ready_insert, ready_in
   );
endinterface

// File: rtl/axi_stream_header_arbiter.sv
// Round-robin per-packet arbiter feeding one shared header-insert block:
// header of the granted source first, then its data beats until last.
//
// state | meaning
// IDLE  | no grant; search requests from rr_ptr with wrap-around
// HDR   | granted source's header channel passed through to the sink
// DATA  | granted source's data channel passed through until last beat
module axi_stream_header_arbiter #(
   parameter int NUM_SRC      = 4,
   parameter int DATA_WD      = 32,
   parameter int DATA_BYTE_WD = DATA_WD / 8,
   parameter int SRC_WD       = $clog2(NUM_SRC),
   parameter int CNT_WD       = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   axi_stream_header_arbiter_if.slave  src,
   axi_stream_header_arbiter_if.master snk,
   output logic [SRC_WD-1:0]     grant_id,
   output logic                  busy,
   output logic                  pkt_done,
   output logic [CNT_WD-1:0]     pkt_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      DATA = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [SRC_WD-1:0] rr_ptr;
   logic [SRC_WD-1:0] pick;
   logic              req_any;
   logic              hdr_fire;
   logic              last_fire;

   // Iterate from the farthest offset down so the nearest requester at or
   // after rr_ptr is the last one written and therefore wins.
   always_comb begin
      int               idx_int;
      logic [SRC_WD-1:0] idx;
      pick    = '0;
      req_any = 1'b0;
      idx_int = 0;
      idx     = '0;
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
         idx_int = (int'(rr_ptr) + k) % NUM_SRC;
         idx     = SRC_WD'(idx_int);
         if (src.valid_insert[idx]) begin
            pick    = idx;
            req_any = 1'b1;
         end
      end
   end

   always_comb begin
      int gi;
      gi               = int'(grant_id);
      state_nxt        = state;
      hdr_fire         = 1'b0;
      last_fire        = 1'b0;
      src.ready_insert = '0;
      src.ready_in     = '0;
      snk.valid_insert = '0;
      snk.data_insert  = '0;
      snk.keep_insert  = '0;
      snk.valid_in     = '0;
      snk.data_in      = '0;
      snk.keep_in      = '0;
      snk.last_in      = '0;
      case (state)
         IDLE: begin
            if (req_any) state_nxt = HDR;
         end
         HDR: begin
            snk.valid_insert[0]        = src.valid_insert[grant_id];
            snk.data_insert            = src.data_insert[gi*DATA_WD +: DATA_WD];
            snk.keep_insert            = src.keep_insert[gi*DATA_BYTE_WD +: DATA_BYTE_WD];
            src.ready_insert[grant_id] = snk.ready_insert[0];
            hdr_fire = src.valid_insert[grant_id] & snk.ready_insert[0];
            if (hdr_fire) state_nxt = DATA;
         end
         DATA: begin
            snk.valid_in[0]        = src.valid_in[grant_id];
            snk.data_in            = src.data_in[gi*DATA_WD +: DATA_WD];
            snk.keep_in            = src.keep_in[gi*DATA_BYTE_WD +: DATA_BYTE_WD];
            snk.last_in[0]         = src.last_in[grant_id];
            src.ready_in[grant_id] = snk.ready_in[0];
            last_fire = src.valid_in[grant_id] & snk.ready_in[0] & src.last_in[grant_id];
            if (last_fire) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         grant_id <= '0;
         rr_ptr   <= '0;
         pkt_cnt  <= '0;
         pkt_done <= 1'b0;
      end else begin
         state    <= state_nxt;
         pkt_done <= last_fire;
         if (state == IDLE && req_any) grant_id <= pick;
         if (last_fire) begin
            pkt_cnt <= pkt_cnt + 1'b1;
            if (int'(grant_id) == NUM_SRC - 1) rr_ptr <= '0;
            else                               rr_ptr <= grant_id + 1'b1;
         end
      end
   end

   assign busy = (state != IDLE);

endmodule
